// File: rtl/clint_mmio_initiator.sv
// LSU-side initiator for the CLINT register bus.
// Turns 1/2/4/8-byte load/store requests into aligned 64-bit accesses.
module clint_mmio_initiator #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic                  req_wen,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [DATA_WIDTH-1:0] clint_addr,
    output logic [DATA_WIDTH-1:0] clint_wdata,
    output logic                  clint_wen,
    input  logic [DATA_WIDTH-1:0] clint_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        RESP
    } state_t;

    state_t state;
    state_t next_state;

    logic [DATA_WIDTH-1:0] cap_addr;
    logic [DATA_WIDTH-1:0] cap_wdata;
    logic                  cap_wen;
    logic [1:0]            cap_size;
    logic                  cap_uns;
    logic [DATA_WIDTH-1:0] merge_buf;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;

    logic                  accept;
    logic                  misaligned;
    logic [5:0]            shamt;
    logic [DATA_WIDTH-1:0] lane;
    logic [DATA_WIDTH-1:0] load_ext;
    logic [7:0]            size_mask;
    logic [7:0]            byte_mask;
    logic [DATA_WIDTH-1:0] wdata_sh;
    logic [DATA_WIDTH-1:0] merged;

    assign accept = req_valid && (state == IDLE);

    always_comb begin
        misaligned = 1'b0;
        unique case (req_size)
            2'd0: misaligned = 1'b0;
            2'd1: misaligned = req_addr[0];
            2'd2: misaligned = |req_addr[1:0];
            2'd3: misaligned = |req_addr[2:0];
        endcase
    end

    // Byte lane of the addressed access within the 64-bit word
    assign shamt = {cap_addr[2:0], 3'b000};
    assign lane  = clint_rdata >> shamt;

    always_comb begin
        load_ext = '0;
        unique case (cap_size)
            2'd0: load_ext = cap_uns ? {56'd0, lane[7:0]}
                                     : {{56{lane[7]}}, lane[7:0]};
            2'd1: load_ext = cap_uns ? {48'd0, lane[15:0]}
                                     : {{48{lane[15]}}, lane[15:0]};
            2'd2: load_ext = cap_uns ? {32'd0, lane[31:0]}
                                     : {{32{lane[31]}}, lane[31:0]};
            2'd3: load_ext = lane;
        endcase
    end

    always_comb begin
        size_mask = 8'h00;
        unique case (cap_size)
            2'd0: size_mask = 8'h01;
            2'd1: size_mask = 8'h03;
            2'd2: size_mask = 8'h0F;
            2'd3: size_mask = 8'hFF;
        endcase
    end

    // Aligned requests never push the mask past byte 7
    assign byte_mask = size_mask << cap_addr[2:0];
    assign wdata_sh  = cap_wdata << shamt;

    always_comb begin
        merged = merge_buf;
        for (int i = 0; i < 8; i++) begin
            if (byte_mask[i]) begin
                merged[8*i +: 8] = wdata_sh[8*i +: 8];
            end
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (misaligned) begin
                        next_state = RESP;
                    end else if (!req_wen) begin
                        next_state = READ;
                    end else if (req_size == 2'd3) begin
                        next_state = WRITE;
                    end else begin
                        next_state = READ;
                    end
                end
            end
            READ:  next_state = cap_wen ? WRITE : RESP;
            WRITE: next_state = RESP;
            RESP: begin
                if (resp_ready) begin
                    next_state = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_wen   <= 1'b0;
            cap_size  <= 2'd0;
            cap_uns   <= 1'b0;
            merge_buf <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            if (accept) begin
                cap_addr  <= req_addr;
                cap_wdata <= req_wdata;
                cap_wen   <= req_wen;
                cap_size  <= req_size;
                cap_uns   <= req_unsigned;
                rdata_q   <= '0;
                err_q     <= misaligned;
            end
            if (state == READ) begin
                merge_buf <= clint_rdata;
                if (!cap_wen) begin
                    rdata_q <= load_ext;
                end
            end
            if (state == RESP && resp_ready) begin
                rdata_q <= '0;
                err_q   <= 1'b0;
            end
        end
    end

    assign req_ready   = (state == IDLE);
    assign resp_valid  = (state == RESP);
    assign resp_rdata  = rdata_q;
    assign resp_err    = err_q;
    assign clint_wen   = (state == WRITE);
    assign clint_wdata = (state == WRITE) ? merged : '0;
    assign clint_addr  = (state == READ || state == WRITE)
                       ? {cap_addr[DATA_WIDTH-1:3], 3'b000} : '0;

endmodule

// File: tb/tb_clint_mmio_initiator.sv
// Directed bench for clint_mmio_initiator with a small CLINT register model.
module tb_clint_mmio_initiator;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic        req_wen;
    logic [63:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic [63:0] clint_addr;
    logic [63:0] clint_wdata;
    logic        clint_wen;
    logic [63:0] clint_rdata;

    clint_mmio_initiator #(.DATA_WIDTH(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_wen      (req_wen),
        .req_wdata    (req_wdata),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .clint_addr   (clint_addr),
        .clint_wdata  (clint_wdata),
        .clint_wen    (clint_wen),
        .clint_rdata  (clint_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // CLINT model: msip, mtimecmp0, mtimecmp1, mtime; everything else reads 0
    logic [63:0] creg [4];

    always_comb begin
        clint_rdata = '0;
        case (clint_addr)
            64'h0200_0000: clint_rdata = creg[0];
            64'h0200_4000: clint_rdata = creg[1];
            64'h0200_4008: clint_rdata = creg[2];
            64'h0200_BFF8: clint_rdata = creg[3];
            default:       clint_rdata = '0;
        endcase
    end

    function automatic int reg_idx(input logic [63:0] a);
        logic [63:0] al;
        al = {a[63:3], 3'b000};
        case (al)
            64'h0200_0000: return 0;
            64'h0200_4000: return 1;
            64'h0200_4008: return 2;
            64'h0200_BFF8: return 3;
            default:       return -1;
        endcase
    endfunction

    int total = 0;
    int bad = 0;
    int bus_cyc;
    int wcnt;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Advance to the next falling edge and let the CLINT model see the bus
    task automatic tick();
        int k;
        @(negedge clk);
        if (clint_addr != 64'd0) bus_cyc++;
        if (clint_wen) begin
            wcnt++;
            k = reg_idx(clint_addr);
            if (k >= 0) creg[k] = clint_wdata;
        end
    endtask

    task automatic wait_resp(output int lat);
        lat = 0;
        while (!resp_valid && lat < 8) begin
            tick();
            lat++;
        end
    endtask

    task automatic drive(input logic wen, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [1:0] size,
                         input logic uns);
        req_valid    = 1'b1;
        req_wen      = wen;
        req_addr     = addr;
        req_wdata    = wdata;
        req_size     = size;
        req_unsigned = uns;
    endtask

    typedef struct {
        string       name;
        logic        wen;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [1:0]  size;
        logic        uns;
        logic [63:0] pre;
        logic [63:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_bus;
        int          exp_wen;
        logic [63:0] exp_mem;
    } vec_t;

    vec_t vt[16];

    function automatic vec_t mk(
        input string n, input logic w, input logic [63:0] a,
        input logic [63:0] wd, input logic [1:0] s, input logic u,
        input logic [63:0] p, input logic [63:0] er, input logic ee,
        input int el, input int eb, input int ew, input logic [63:0] em);
        vec_t v;
        v.name = n; v.wen = w; v.addr = a; v.wdata = wd; v.size = s;
        v.uns = u; v.pre = p; v.exp_rdata = er; v.exp_err = ee;
        v.exp_lat = el; v.exp_bus = eb; v.exp_wen = ew; v.exp_mem = em;
        return v;
    endfunction

    int lat;
    int k;
    logic [63:0] held;

    initial begin
        vt[0]  = mk("st8", 1, 64'h200_4000, 64'h1234, 3, 0,
                    64'hDEAD, 0, 0, 2, 1, 1, 64'h1234);
        vt[1]  = mk("ld4s", 0, 64'h200_4004, 0, 2, 0,
                    64'h8000_0001_0000_0002, 64'hFFFF_FFFF_8000_0001,
                    0, 2, 1, 0, 64'h8000_0001_0000_0002);
        vt[2]  = mk("ld4u", 0, 64'h200_4004, 0, 2, 1,
                    64'h8000_0001_0000_0002, 64'h0000_0000_8000_0001,
                    0, 2, 1, 0, 64'h8000_0001_0000_0002);
        vt[3]  = mk("st1", 1, 64'h200_4003, 64'hAB, 0, 0,
                    64'h1111_1111_1111_1111, 0, 0, 3, 2, 1,
                    64'h1111_1111_AB11_1111);
        vt[4]  = mk("mis_ld2", 0, 64'h200_4001, 0, 1, 0,
                    64'h55, 0, 1, 1, 0, 0, 64'h55);
        vt[5]  = mk("ld1s", 0, 64'h200_4007, 0, 0, 0,
                    64'h8011_2233_4455_6677, 64'hFFFF_FFFF_FFFF_FF80,
                    0, 2, 1, 0, 64'h8011_2233_4455_6677);
        vt[6]  = mk("ld2u", 0, 64'h200_4006, 0, 1, 1,
                    64'h8011_2233_4455_6677, 64'h8011,
                    0, 2, 1, 0, 64'h8011_2233_4455_6677);
        vt[7]  = mk("ld2s", 0, 64'h200_4006, 0, 1, 0,
                    64'h8011_2233_4455_6677, 64'hFFFF_FFFF_FFFF_8011,
                    0, 2, 1, 0, 64'h8011_2233_4455_6677);
        vt[8]  = mk("ld8", 0, 64'h200_BFF8, 0, 3, 0,
                    64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF,
                    0, 2, 1, 0, 64'h0123_4567_89AB_CDEF);
        vt[9]  = mk("st2", 1, 64'h200_4006, 64'hFFFF_CAFE, 1, 0,
                    64'h0, 0, 0, 3, 2, 1, 64'hCAFE_0000_0000_0000);
        vt[10] = mk("st4", 1, 64'h200_4008, 64'h1_DEAD_BEEF, 2, 0,
                    64'hAAAA_AAAA_AAAA_AAAA, 0, 0, 3, 2, 1,
                    64'hAAAA_AAAA_DEAD_BEEF);
        vt[11] = mk("mis_st8", 1, 64'h200_4004, 64'h99, 3, 0,
                    64'h77, 0, 1, 1, 0, 0, 64'h77);
        vt[12] = mk("mis_st4", 1, 64'h200_4002, 64'h99, 2, 0,
                    64'h66, 0, 1, 1, 0, 0, 64'h66);
        vt[13] = mk("ld_out", 0, 64'h8000_0000, 0, 3, 0,
                    0, 0, 0, 2, 1, 0, 0);
        vt[14] = mk("st_out", 1, 64'h8000_0010, 64'h5A, 0, 0,
                    0, 0, 0, 3, 2, 1, 0);
        vt[15] = mk("ld1u_msip", 0, 64'h200_0000, 0, 0, 1,
                    64'h1, 64'h1, 0, 2, 1, 0, 64'h1);

        for (int i = 0; i < 4; i++) creg[i] = '0;
        bus_cyc = 0;
        wcnt = 0;

        // Reset held with a request pending
        rst = 1'b0;
        resp_ready = 1'b1;
        creg[1] = 64'h0BAD_F00D_1234_5678;
        drive(0, 64'h200_4000, 0, 3, 0);
        repeat (3) tick();
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_clint_wen", 64'(clint_wen), 64'd0);
        chk("rst_clint_addr", clint_addr, 64'd0);
        chk("rst_resp_rdata", resp_rdata, 64'd0);
        rst = 1'b1;
        tick();
        chk("rst_accept", 64'(req_ready), 64'd0);
        req_valid = 1'b0;
        wait_resp(lat);
        chk("rst_ld_rdata", resp_rdata, 64'h0BAD_F00D_1234_5678);
        tick();

        // Table-driven vectors
        for (int i = 0; i < 16; i++) begin
            k = reg_idx(vt[i].addr);
            if (k >= 0) creg[k] = vt[i].pre;
            bus_cyc = 0;
            wcnt = 0;
            drive(vt[i].wen, vt[i].addr, vt[i].wdata, vt[i].size, vt[i].uns);
            tick();
            req_valid = 1'b0;
            lat = 1;
            while (!resp_valid && lat < 8) begin
                tick();
                lat++;
            end
            chk({vt[i].name, "_rdata"}, resp_rdata, vt[i].exp_rdata);
            chk({vt[i].name, "_err"}, 64'(resp_err), 64'(vt[i].exp_err));
            chk({vt[i].name, "_lat"}, 64'(lat), 64'(vt[i].exp_lat));
            chk({vt[i].name, "_bus"}, 64'(bus_cyc), 64'(vt[i].exp_bus));
            chk({vt[i].name, "_wen"}, 64'(wcnt), 64'(vt[i].exp_wen));
            if (k >= 0) chk({vt[i].name, "_mem"}, creg[k], vt[i].exp_mem);
            tick();
        end

        // Backpressure with a pending request
        creg[1] = 64'h0000_0000_CAFE_F00D;
        creg[2] = 64'h0;
        resp_ready = 1'b0;
        drive(0, 64'h200_4000, 0, 2, 1);
        tick();
        req_valid = 1'b0;
        wait_resp(lat);
        held = resp_rdata;
        chk("bp_rdata", held, 64'h0000_0000_CAFE_F00D);
        drive(1, 64'h200_4008, 64'h77, 3, 0);
        bus_cyc = 0;
        for (int j = 0; j < 5; j++) begin
            tick();
            chk("bp_valid", 64'(resp_valid), 64'd1);
            chk("bp_hold", resp_rdata, held);
            chk("bp_ready", 64'(req_ready), 64'd0);
        end
        chk("bp_nobus", 64'(bus_cyc), 64'd0);
        resp_ready = 1'b1;
        tick();
        chk("bp_idle_ready", 64'(req_ready), 64'd1);
        chk("bp_idle_valid", 64'(resp_valid), 64'd0);
        tick();
        chk("bp_pend_wen", 64'(clint_wen), 64'd1);
        chk("bp_pend_ready", 64'(req_ready), 64'd0);
        req_valid = 1'b0;
        wait_resp(lat);
        chk("bp_pend_mem", creg[2], 64'h77);
        tick();

        // Asynchronous reset mid read-modify-write aborts it
        creg[1] = 64'h2222_2222_2222_2222;
        drive(1, 64'h200_4001, 64'h99, 0, 0);
        tick();
        req_valid = 1'b0;
        chk("abort_inread", clint_addr, 64'h200_4000);
        rst = 1'b0;
        #1;
        chk("abort_addr", clint_addr, 64'd0);
        chk("abort_wen", 64'(clint_wen), 64'd0);
        chk("abort_ready", 64'(req_ready), 64'd1);
        tick();
        tick();
        rst = 1'b1;
        wcnt = 0;
        repeat (3) tick();
        chk("abort_noresp", 64'(resp_valid), 64'd0);
        chk("abort_nowrite", 64'(wcnt), 64'd0);
        chk("abort_mem", creg[1], 64'h2222_2222_2222_2222);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got hang want finish");
        $fatal(1, "timeout");
    end

endmodule
